// File: rtl/dmem_responder_if.sv
// Request/response bundle between a CPU load/store unit (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, programmable wait states,
// RV32I byte/half/word loads and stores, plus a sticky trigger-status register.
module dmem_responder #(
    parameter int unsigned              ADDRESS_WIDTH = 16,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              LATENCY       = 2,
    parameter logic [ADDRESS_WIDTH-1:0] TRIGGER_ADDR  = 16'hFFFC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    dmem_responder_if.slave bus
);
    localparam int unsigned DEPTH    = 2 ** (ADDRESS_WIDTH - 2);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_next;
    logic [3:0]               cnt;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic                     trigger_sticky;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     go_resp;
    logic                     op_we;
    logic [2:0]               op_funct3;
    logic [ADDRESS_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0]    op_wdata;
    logic [1:0]               off;
    logic                     is_trig;
    logic                     op_err;
    logic [3:0]               byte_en;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [DATA_WIDTH-1:0]    rd_shift;
    logic [DATA_WIDTH-1:0]    wd_shift;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic [DATA_WIDTH-1:0]    load_val;
    logic                     do_store;
    logic                     trig_clear;

    // With zero wait states the commit happens on the accept edge, so operands come straight from the bus.
    assign go_resp   = (state == IDLE && bus.req_valid && ZERO_LAT) || (state == WAIT && cnt == 4'd0);
    assign op_we     = (state == IDLE) ? bus.req_we     : we_q;
    assign op_funct3 = (state == IDLE) ? bus.req_funct3 : funct3_q;
    assign op_addr   = (state == IDLE) ? bus.req_addr   : addr_q;
    assign op_wdata  = (state == IDLE) ? bus.req_wdata  : wdata_q;
    assign off       = op_addr[1:0];
    assign is_trig   = (op_addr[ADDRESS_WIDTH-1:2] == TRIGGER_ADDR[ADDRESS_WIDTH-1:2]);

    always_comb begin
        op_err = 1'b0;
        unique case (op_funct3)
            3'b000, 3'b100: op_err = 1'b0;
            3'b001, 3'b101: op_err = off[0];
            3'b010:         op_err = |off;
            default:        op_err = 1'b1;
        endcase
        if (is_trig && op_funct3 != 3'b010)
            op_err = 1'b1;
    end

    always_comb begin
        rd_word  = is_trig ? {{(DATA_WIDTH-1){1'b0}}, trigger_sticky} : mem[op_addr[ADDRESS_WIDTH-1:2]];
        rd_shift = rd_word >> {off, 3'b000};
        wd_shift = op_wdata << {off, 3'b000};
        byte_en  = '0;
        load_val = '0;
        unique case (op_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
        unique case (op_funct3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'b0, rd_shift[7:0]};
            3'b101:  load_val = {16'b0, rd_shift[15:0]};
            default: load_val = '0;
        endcase
        wr_word = rd_word;
        for (int unsigned i = 0; i < 4; i++)
            if (byte_en[i])
                wr_word[8*i +: 8] = wd_shift[8*i +: 8];
    end

    assign do_store   = go_resp && !rst && op_we && !op_err;
    assign trig_clear = do_store && is_trig && op_wdata[0];

    always_ff @(posedge clk)
        if (do_store && !is_trig)
            mem[op_addr[ADDRESS_WIDTH-1:2]] <= wr_word;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_next = ZERO_LAT ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0)   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            we_q           <= 1'b0;
            funct3_q       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            trigger_sticky <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                cnt      <= CNT_INIT;
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_we) ? '0 : load_val;
            end
            // A trigger seen on the same edge as a clearing store keeps the flag set.
            if (trigger)
                trigger_sticky <= 1'b1;
            else if (trig_clear)
                trigger_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic vs. a byte-array model.
module tb_dmem_responder;
    localparam int unsigned LAT  = 2;
    localparam logic [15:0] TRIG = 16'hFFFC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trigger = 1'b0;
    int   total = 0;
    int   bad = 0;

    dmem_responder_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

    dmem_responder #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH(32),
        .LATENCY(LAT),
        .TRIGGER_ADDR(TRIG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger(trigger),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Issues one request; reports data, error, response delay in negedges after the accept edge,
    // whether req_ready stayed low while busy, and whether the pulse was a single cycle.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [15:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic busy_ok, output logic pulse_ok);
        busy_ok  = 1'b1;
        pulse_ok = 1'b0;
        lat      = -1;
        rd       = 'x;
        er       = 1'bx;
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.req_ready) busy_ok = 1'b0;
            if (bus.rsp_valid) begin
                lat = n;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            pulse_ok = !bus.rsp_valid && bus.req_ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.rsp_valid);
        end
        total++;
        if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er, bok, pok; int lat;
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b010, 3'b010};
        logic [15:0] ads [6] = '{16'h0013, 16'h0013, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        logic [31:0] exp [6] = '{32'hFFFF_FF87, 32'h0000_0087, 32'h0000_4321, 32'h8765_4321,
                                 32'h8765_AA21, 32'h1234_AA21};
        xact(1'b1, 3'b010, 16'h0010, 32'h8765_4321, rd, er, lat, bok, pok);
        total++;
        if (lat !== LAT + 1) begin
            bad++;
            $display("FAIL sw_latency got=%0d want=%0d", lat, LAT + 1);
        end
        total++;
        if (bok !== 1'b1 || pok !== 1'b1) begin
            bad++;
            $display("FAIL sw_handshake busy_ok=%b pulse_ok=%b want 1/1", bok, pok);
        end
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL sw_rsp err=%b rdata=%h want 0/0", er, rd);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 4) xact(1'b1, 3'b000, 16'h0011, 32'h0000_00AA, rd, er, lat, bok, pok);
            if (i == 5) xact(1'b1, 3'b001, 16'h0012, 32'h0000_1234, rd, er, lat, bok, pok);
            xact(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat, bok, pok);
            total++;
            if (rd !== exp[i] || er !== 1'b0) begin
                bad++;
                $display("FAIL load_%0d rdata=%h err=%b want %h/0", i, rd, er, exp[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er, bok, pok; int lat;
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b011, 3'b001, 3'b010};
        logic [15:0] ads [5] = '{16'h0012, 16'h0011, 16'h0010, TRIG, 16'h0010};
        logic        exe [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exd [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_AA21};
        for (int i = 0; i < 5; i++) begin
            xact(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, rd, er, lat, bok, pok);
            total++;
            if (er !== exe[i] || rd !== exd[i]) begin
                bad++;
                $display("FAIL align_%0d err=%b rdata=%h want %b/%h", i, er, rd, exe[i], exd[i]);
            end
        end
    endtask

    task automatic test_trigger();
        logic [31:0] rd; logic er, bok, pok; int lat;
        xact(1'b0, 3'b010, TRIG, 32'h0, rd, er, lat, bok, pok);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL trig_idle rdata=%h want 0", rd); end
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        xact(1'b0, 3'b010, TRIG, 32'h0, rd, er, lat, bok, pok);
        total++;
        if (rd !== 32'h1 || er !== 1'b0) begin bad++; $display("FAIL trig_set rdata=%h err=%b want 1/0", rd, er); end
        trigger = 1'b1;
        xact(1'b1, 3'b010, TRIG, 32'h1, rd, er, lat, bok, pok);
        trigger = 1'b0;
        xact(1'b0, 3'b010, TRIG, 32'h0, rd, er, lat, bok, pok);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL trig_set_wins rdata=%h want 1", rd); end
        xact(1'b1, 3'b010, TRIG, 32'h1, rd, er, lat, bok, pok);
        xact(1'b0, 3'b010, TRIG, 32'h0, rd, er, lat, bok, pok);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL trig_clear rdata=%h want 0", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, bok, pok; int lat; int seen;
        xact(1'b1, 3'b010, 16'h0020, 32'h0, rd, er, lat, bok, pok);
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 16'h0020;
        bus.req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_state ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_no_rsp pulses=%0d want 0", seen); end
        xact(1'b0, 3'b010, 16'h0020, 32'h0, rd, er, lat, bok, pok);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL abort_dropped rdata=%h want 0", rd); end
    endtask

    // Holds req_valid continuously: accepts must come every LAT+2 cycles, response on the last of each.
    task automatic test_back_to_back();
        int period = LAT + 2;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 16'h0010;
        for (int i = 0; i < 4 * period; i++) begin
            total++;
            if (bus.req_ready !== (i % period == 0) || bus.rsp_valid !== (i % period == period - 1)) begin
                bad++;
                $display("FAIL b2b_cycle_%0d ready=%b valid=%b want %b/%b", i, bus.req_ready,
                         bus.rsp_valid, (i % period == 0), (i % period == period - 1));
            end
            if (i % period == period - 1) begin
                total++;
                if (bus.rsp_rdata !== 32'h1234_AA21) begin
                    bad++;
                    $display("FAIL b2b_data_%0d rdata=%h want 1234aa21", i, bus.rsp_rdata);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  mdl [64];
        logic [31:0] rd, wd, exp; logic er, bok, pok, we, exp_err; int lat;
        int          f3tab [10] = '{0, 1, 2, 4, 5, 2, 1, 0, 3, 7};
        int          f3, size, off;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            xact(1'b1, 3'b010, 16'h0100 + 16'(4 * w), wd, rd, er, lat, bok, pok);
            for (int b = 0; b < 4; b++) mdl[4 * w + b] = 8'(wd >> (8 * b));
        end
        for (int t = 0; t < 60; t++) begin
            f3  = f3tab[$urandom_range(0, 9)];
            we  = (f3 == 4 || f3 == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            wd  = $urandom;
            size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
            off = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) off = off - (off % size);
            exp_err = (f3 == 3 || f3 == 6 || f3 == 7) || (off % size != 0);
            exp = 32'h0;
            if (!exp_err && we) begin
                for (int b = 0; b < size; b++) mdl[off + b] = 8'(wd >> (8 * b));
            end else if (!exp_err) begin
                for (int b = 0; b < size; b++) exp = exp | (32'(mdl[off + b]) << (8 * b));
                if (f3 < 4 && size < 4 && exp[8 * size - 1]) exp = exp | (32'hFFFF_FFFF << (8 * size));
            end
            xact(we, 3'(f3), 16'h0100 + 16'(off), wd, rd, er, lat, bok, pok);
            total++;
            if (rd !== exp || er !== exp_err) begin
                bad++;
                $display("FAIL rand_%0d we=%b f3=%0d off=%0d rdata=%h err=%b want %h/%b",
                         t, we, f3, off, rd, er, exp, exp_err);
            end
            total++;
            if (lat !== LAT + 1 || bok !== 1'b1 || pok !== 1'b1) begin
                bad++;
                $display("FAIL rand_timing_%0d lat=%0d busy_ok=%b pulse_ok=%b want %0d/1/1", t, lat, bok, pok, LAT + 1);
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        test_reset();
        test_basic();
        test_misaligned();
        test_trigger();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU data-memory load/store interface: accepts one request at a time over a valid/ready handshake.
- Services byte, halfword and word accesses with a programmable wait-state latency.
- Returns sign- or zero-extended load data with a one-cycle response pulse.
- Also exposes a memory-mapped sticky trigger-status register; replaces the single-cycle data memory for multi-cycle and pipelined cores.

Parameters:
- ADDRESS_WIDTH, 16, byte-address width; storage depth = 2**(ADDRESS_WIDTH-2) words.
- DATA_WIDTH, 32, data word width (only 32 supported).
- LATENCY, 2, wait-state cycles between acceptance and response (0..15).
- TRIGGER_ADDR, 16'hFFFC, word address of the trigger-status register (word-aligned).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data (0 for stores/errors)
- rsp_err  out  1  misaligned or illegal funct3, valid with rsp_valid
- trigger  in  1  external trigger level, sampled each edge

Behaviour:
- Reset:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, trigger_sticky=0, wait counter=0.
  - Storage array not reset.
  - Reset mid-operation aborts the pending request; a store not yet committed is dropped; no response is issued.
- FSM IDLE / WAIT / RESP:
  - IDLE: req_ready=1. On req_valid at edge k, latch we/funct3/addr/wdata. Go to WAIT with counter=LATENCY-1, or to RESP directly if LATENCY=0.
  - WAIT: req_ready=0, decrement counter. At counter=0 go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, between edges k+LATENCY and k+LATENCY+1, then IDLE. req_ready is 0 in RESP, so there are no back-to-back accepts.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Commit: store write and load data capture happen on the edge entering RESP (edge k+LATENCY). req_* inputs are ignored outside IDLE.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Violation or funct3 in {011,110,111} sets rsp_err=1, no write, rsp_rdata=0.
- Stores, byte lanes by addr[1:0]:
  - sb writes wdata[7:0] to lane addr[1:0].
  - sh writes wdata[15:0] to lanes {addr[1],0},{addr[1],1}.
  - sw writes all 4 lanes. Other bytes are unchanged (little-endian).
- Loads:
  - Select byte/half from the word at addr[ADDRESS_WIDTH-1:2].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the full word.
- Trigger register at TRIGGER_ADDR:
  - Set: trigger_sticky <= 1 on any edge where trigger=1.
  - Read (lw) returns {31'b0, trigger_sticky}.
  - sw with wdata[0]=1 clears it at the commit edge. Same-edge set and clear: set wins.
  - Non-word access to TRIGGER_ADDR gives rsp_err=1.
  - The register shadows the underlying storage word.
- Outputs: rsp_rdata/rsp_err are held at last values when rsp_valid=0 (not checked by bench).

Test Plan:
- rst for 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0. Then sw 32'h8765_4321 @0x0010, LATENCY=2, accepted edge k -> rsp_valid only in cycle k+2..k+3, rsp_err=0, req_ready=0 from k to k+3.
- After above: lb @0x0013 -> rsp_rdata=32'hFFFF_FF87; lbu @0x0013 -> 32'h0000_0087; lh @0x0010 -> 32'h0000_4321; lw @0x0010 -> 32'h8765_4321.
- sb 32'hAA @0x0011, then lw @0x0010 -> 32'h8765_AA21. sh 32'h1234 @0x0012, then lw -> 32'h1234_AA21.
- lw @0x0012 and sh @0x0011 -> rsp_err=1, rsp_rdata=0, following lw @0x0010 unchanged (32'h1234_AA21). funct3=011 -> rsp_err=1.
- trigger pulse 1 cycle -> lw @TRIGGER_ADDR returns 1. sw 1 @TRIGGER_ADDR with trigger held high at commit edge -> next lw returns 1. Repeat with trigger low -> returns 0.
- Accept sw 32'hDEAD_BEEF @0x0020 (prior contents 32'h0), assert rst during WAIT -> no rsp_valid, req_ready=1 next cycle, lw @0x0020 returns 32'h0. Held req_valid during WAIT is not accepted until RESP completes.
